adj_fm_wm_result_reader: RTL and testbench

- Reader and classifier on the output side of the ADJ x (FM x WM) vector-multiplication stage.
- Drives read_row into the multiplier and captures the returned dot_product row.
- Computes the per-node argmax over the WEIGHT_COLS class scores.
- Streams one {row, class index, score} result per node over a valid/ready handshake, then signals completion of the graph.

---
 rtl/gcn_pkg.sv | 19 +
 rtl/gcn_argmax_step.sv | 33 +++
 rtl/adj_fm_wm_result_reader.sv | 124 ++++++++++++
 tb/tb_adj_fm_wm_result_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared defaults, reader states and element type for the GCN result path
package gcn_pkg;

  localparam int DEF_NUM_OF_NODES   = 6;
  localparam int DEF_WEIGHT_COLS    = 3;
  localparam int DEF_DOT_PROD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    OUTPUT  = 3'd4,
    DONE    = 3'd5
  } reader_state_t;

  typedef logic [DEF_DOT_PROD_WIDTH-1:0] dot_elem_t;

endpackage

// File: rtl/gcn_argmax_step.sv
// rtl/gcn_argmax_step.sv - registered running-max unit, ties keep the lower index
module gcn_argmax_step
  import gcn_pkg::*;
#(
  parameter int WIDTH     = DEF_DOT_PROD_WIDTH,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [WIDTH-1:0]     init_score,
  input  logic                 step,
  input  logic [IDX_WIDTH-1:0] step_idx,
  input  logic [WIDTH-1:0]     step_score,
  output logic [IDX_WIDTH-1:0] best_idx,
  output logic [WIDTH-1:0]     best_score
);

  // init seeds the max with column 0; step replaces it only on a strictly larger score
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (init) begin
      best_idx   <= '0;
      best_score <= init_score;
    end else if (step && (step_score > best_score)) begin
      best_idx   <= step_idx;
      best_score <= step_score;
    end
  end

endmodule

// File: rtl/adj_fm_wm_result_reader.sv
// rtl/adj_fm_wm_result_reader.sv - reads dot-product rows, picks per-node argmax, streams results
module adj_fm_wm_result_reader
  import gcn_pkg::*;
#(
  parameter int NUM_OF_NODES   = DEF_NUM_OF_NODES,
  parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
  parameter int ROW_WIDTH      = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1,
  parameter int COL_WIDTH      = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic [ROW_WIDTH-1:0]                read_row,
  input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] dot_product,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ROW_WIDTH-1:0]                out_row,
  output logic [COL_WIDTH-1:0]                out_class,
  output logic [DOT_PROD_WIDTH-1:0]           out_score,
  output logic                                busy,
  output logic                                done
);

  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(NUM_OF_NODES - 1);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(WEIGHT_COLS - 1);

  reader_state_t state;
  reader_state_t state_next;

  logic [ROW_WIDTH-1:0] row_cnt;
  logic [COL_WIDTH-1:0] col_cnt;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_buf;

  logic                      max_init;
  logic                      max_step;
  logic [COL_WIDTH-1:0]      best_idx;
  logic [DOT_PROD_WIDTH-1:0] best_score;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE so it cannot restart a run
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = (WEIGHT_COLS == 1) ? OUTPUT : COMPARE;
      COMPARE: if (col_cnt == LAST_COL) state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = (row_cnt == LAST_ROW) ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row/column counters, row address and row buffer; read_row is loaded as ISSUE is entered
  // so the multiplier sees the new address during ISSUE and answers during WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt  <= '0;
      read_row <= '0;
      col_cnt  <= '0;
      row_buf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt  <= '0;
            read_row <= '0;
          end
        end
        WAIT: begin
          row_buf <= dot_product;
          col_cnt <= COL_WIDTH'(1);
        end
        COMPARE: begin
          col_cnt <= col_cnt + 1'b1;
        end
        OUTPUT: begin
          if (out_ready && (row_cnt != LAST_ROW)) begin
            row_cnt  <= row_cnt + 1'b1;
            read_row <= row_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign max_init = (state == WAIT);
  assign max_step = (state == COMPARE);

  gcn_argmax_step #(
    .WIDTH     (DOT_PROD_WIDTH),
    .IDX_WIDTH (COL_WIDTH)
  ) u_argmax (
    .clk        (clk),
    .reset      (reset),
    .init       (max_init),
    .init_score (dot_product[DOT_PROD_WIDTH-1:0]),
    .step       (max_step),
    .step_idx   (col_cnt),
    .step_score (row_buf[col_cnt]),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

  // Result fields come straight from registers that are frozen while OUTPUT waits for ready
  assign out_valid = (state == OUTPUT);
  assign out_row   = row_cnt;
  assign out_class = best_idx;
  assign out_score = best_score;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_adj_fm_wm_result_reader.sv
// tb/tb_adj_fm_wm_result_reader.sv - directed self-checking bench for adj_fm_wm_result_reader
module tb_adj_fm_wm_result_reader;

  localparam int N  = 6;
  localparam int C  = 3;
  localparam int W  = 16;
  localparam int RW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [RW-1:0] read_row;
  logic [C*W-1:0] dot_product = '0;
  logic          out_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_class;
  logic [W-1:0]  out_score;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [C*W-1:0] mem [N];
  int exp_class [N];
  int exp_score [N];

  int res_row [8];
  int res_class [8];
  int res_score [8];
  int res_k [8];
  int n_res;
  int done_k;
  int done_cnt;
  int fall_k;

  adj_fm_wm_result_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .read_row    (read_row),
    .dot_product (dot_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_class   (out_class),
    .out_score   (out_score),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Multiplier model: registered lookup, answers one cycle after read_row changes
  always_ff @(posedge clk) begin
    dot_product <= (int'(read_row) < N) ? mem[read_row] : '0;
  end

  task automatic run_collect(input bit noise);
    n_res = 0; done_k = -1; done_cnt = 0; fall_k = -1;
    for (int i = 0; i < 8; i++) begin
      res_row[i] = -1; res_class[i] = -1; res_score[i] = -1; res_k[i] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid && n_res < 8) begin
        res_row[n_res] = int'(out_row);
        res_class[n_res] = int'(out_class);
        res_score[n_res] = int'(out_score);
        res_k[n_res] = k;
        n_res++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      start = noise && (k == 3 || k == 12 || k == 21 || k == 31);
      if (done_k >= 0 && !busy) begin
        fall_k = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({read_row, out_valid, out_row, out_class, out_score, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {read_row, out_valid, out_row, out_class, out_score, busy, done});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: valid/busy/done=%b expected 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_single_row();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1 || read_row !== 3'd0) begin
          n_errors++;
          $display("FAIL issue_row0: busy=%b read_row=%0d expected busy=1 read_row=0", busy, read_row);
        end
      end
      if (k < 5) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL early_valid: cycle %0d out_valid=%b expected 0", k, out_valid);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b1 || out_row !== 3'd0 || out_class !== 2'd0 || out_score !== 16'd11488) begin
          n_errors++;
          $display("FAIL row0_result: valid=%b row=%0d class=%0d score=%0d expected 1 0 0 11488",
                   out_valid, out_row, out_class, out_score);
        end
      end
    end
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL single_row_drain: busy=%b expected 0 within budget", busy);
    end
  endtask

  task automatic test_full_run();
    run_collect(1'b0);
    n_checks++;
    if (n_res !== N) begin
      n_errors++;
      $display("FAIL full_count: results=%0d expected %0d", n_res, N);
    end
    for (int r = 0; r < N; r++) begin
      n_checks++;
      if (res_row[r] !== r || res_class[r] !== exp_class[r] || res_score[r] !== exp_score[r] ||
          res_k[r] !== 5 * (r + 1)) begin
        n_errors++;
        $display("FAIL full_row%0d: row=%0d class=%0d score=%0d cycle=%0d expected %0d %0d %0d %0d",
                 r, res_row[r], res_class[r], res_score[r], res_k[r], r, exp_class[r], exp_score[r], 5 * (r + 1));
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_k !== 31 || fall_k !== 32) begin
      n_errors++;
      $display("FAIL full_done: pulses=%0d done_cycle=%0d busy_fall=%0d expected 1 31 32", done_cnt, done_k, fall_k);
    end
  endtask

  task automatic test_start_noise();
    run_collect(1'b1);
    for (int r = 0; r < N; r++) begin
      n_checks++;
      if (res_row[r] !== r || res_class[r] !== exp_class[r] || res_k[r] !== 5 * (r + 1)) begin
        n_errors++;
        $display("FAIL noise_row%0d: row=%0d class=%0d cycle=%0d expected %0d %0d %0d",
                 r, res_row[r], res_class[r], res_k[r], r, exp_class[r], 5 * (r + 1));
      end
    end
    n_checks++;
    if (n_res !== N || done_cnt !== 1 || done_k !== 31 || fall_k !== 32) begin
      n_errors++;
      $display("FAIL noise_done: results=%0d pulses=%0d done_cycle=%0d busy_fall=%0d expected 6 1 31 32",
               n_res, done_cnt, done_k, fall_k);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL noise_restart: busy=%b expected 0 after run", busy);
    end
  endtask

  task automatic test_backpressure();
    int stall_n;
    logic [RW-1:0] snap_row;
    logic [CW-1:0] snap_class;
    logic [W-1:0] snap_score;
    int row3_k;
    int dk;
    stall_n = 0; row3_k = -1; dk = -1;
    snap_row = '0; snap_class = '0; snap_score = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_row == 3'd2 && stall_n <= 4) begin
        if (stall_n == 0) begin
          snap_row = out_row; snap_class = out_class; snap_score = out_score;
        end else begin
          n_checks++;
          if (out_valid !== 1'b1 || out_row !== snap_row || out_class !== snap_class ||
              out_score !== snap_score || read_row !== 3'd2) begin
            n_errors++;
            $display("FAIL bp_hold%0d: valid=%b row=%0d class=%0d score=%0d read_row=%0d expected 1 %0d %0d %0d 2",
                     stall_n, out_valid, out_row, out_class, out_score, read_row, snap_row, snap_class, snap_score);
          end
        end
        out_ready = (stall_n >= 4);
        stall_n++;
      end else begin
        out_ready = 1'b1;
      end
      if (k == 20) begin
        n_checks++;
        if (read_row !== 3'd3 || out_valid !== 1'b0 || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_issue3: read_row=%0d valid=%b busy=%b expected 3 0 1", read_row, out_valid, busy);
        end
      end
      if (out_valid && out_row == 3'd3 && row3_k < 0) row3_k = k;
      if (done && dk < 0) dk = k;
      if (dk >= 0 && !busy) break;
    end
    out_ready = 1'b1;
    n_checks++;
    if (snap_class !== 2'd2 || snap_score !== 16'd8976 || stall_n !== 5) begin
      n_errors++;
      $display("FAIL bp_result: class=%0d score=%0d stalls=%0d expected 2 8976 5", snap_class, snap_score, stall_n);
    end
    n_checks++;
    if (row3_k !== 24 || dk !== 35) begin
      n_errors++;
      $display("FAIL bp_timing: row3_cycle=%0d done_cycle=%0d expected 24 35", row3_k, dk);
    end
  endtask

  task automatic test_async_reset();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done++;
    end
    n_checks++;
    if (busy !== 1'b1 || read_row !== 3'd3 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_reset: busy=%b read_row=%0d valid=%b expected 1 3 0", busy, read_row, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({read_row, out_valid, out_row, out_class, out_score, busy, done} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got %h expected 0",
               {read_row, out_valid, out_row, out_class, out_score, busy, done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen_done++;
      n_checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        n_errors++;
        $display("FAIL post_reset_idle%0d: valid/busy/done=%b expected 000", k, {out_valid, busy, done});
      end
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_errors++;
      $display("FAIL reset_no_done: done pulses=%0d expected 0", seen_done);
    end
    run_collect(1'b0);
    for (int r = 0; r < N; r++) begin
      n_checks++;
      if (res_row[r] !== r || res_class[r] !== exp_class[r] || res_score[r] !== exp_score[r]) begin
        n_errors++;
        $display("FAIL rerun_row%0d: row=%0d class=%0d score=%0d expected %0d %0d %0d",
                 r, res_row[r], res_class[r], res_score[r], r, exp_class[r], exp_score[r]);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_k !== 31) begin
      n_errors++;
      $display("FAIL rerun_done: pulses=%0d done_cycle=%0d expected 1 31", done_cnt, done_k);
    end
  endtask

  task automatic test_back_to_back();
    run_collect(1'b0);
    run_collect(1'b0);
    n_checks++;
    if (n_res !== N || res_row[5] !== 5 || res_class[4] !== 1 || res_score[4] !== 200 ||
        done_k !== 31 || fall_k !== 32) begin
      n_errors++;
      $display("FAIL back_to_back: results=%0d row5=%0d class4=%0d score4=%0d done=%0d fall=%0d expected 6 5 1 200 31 32",
               n_res, res_row[5], res_class[4], res_score[4], done_k, fall_k);
    end
  endtask

  initial begin
    mem[0] = {16'd0,     16'd0,    16'd11488};
    mem[1] = {16'd8976,  16'd9853, 16'd7687};
    mem[2] = {16'd8976,  16'd6684, 16'd0};
    mem[3] = {16'd0,     16'd6093, 16'd6093};
    mem[4] = {16'd200,   16'd200,  16'd100};
    mem[5] = {16'd65535, 16'd0,    16'd65535};
    exp_class[0] = 0; exp_score[0] = 11488;
    exp_class[1] = 1; exp_score[1] = 9853;
    exp_class[2] = 2; exp_score[2] = 8976;
    exp_class[3] = 0; exp_score[3] = 6093;
    exp_class[4] = 1; exp_score[4] = 200;
    exp_class[5] = 0; exp_score[5] = 65535;

    test_reset();
    test_single_row();
    test_full_run();
    test_start_noise();
    test_backpressure();
    test_async_reset();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
